// File: rtl/mul8_pkg.sv
// Shared constants and FSM encoding for the sequential 8x8 shift-add multiplier.
package mul8_pkg;

    localparam int unsigned WIDTH = 8;

    localparam logic [3:0] CNT_LAST = 4'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/CLA_8bit.sv
// 8-bit carry-lookahead adder: sum, carry-out, signed overflow and group propagate/generate.
module CLA_8bit (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       Ci,
    output logic [7:0] S,
    output logic       Co,
    output logic       OF,
    output logic       PG,
    output logic       GG
);

    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;
    logic       gg;

    always_comb begin
        g    = A & B;
        p    = A ^ B;
        c    = '0;
        c[0] = Ci;
        for (int i = 0; i < 8; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        // Group generate ignores Ci so it can feed a higher-level lookahead unit.
        gg = 1'b0;
        for (int i = 0; i < 8; i++) begin
            gg = g[i] | (p[i] & gg);
        end
        S  = p ^ c[7:0];
        Co = c[8];
        OF = c[8] ^ c[7];
        PG = &p;
        GG = gg;
    end

endmodule

// File: rtl/mul8_seq.sv
// Sequential 8x8 unsigned shift-add multiplier with start/busy/done handshake.
// One partial-product addition per cycle through a shared CLA_8bit.
module mul8_seq
    import mul8_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p,
    output logic                 ovf
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic [WIDTH-1:0] acc_shift;

    assign addend    = q_q[0] ? m_q : '0;
    assign acc_shift = {carry, sum[WIDTH-1:1]};

    CLA_8bit u_cla (
        .A  (acc_q),
        .B  (addend),
        .Ci (1'b0),
        .S  (sum),
        .Co (carry),
        .OF (),
        .PG (),
        .GG ()
    );

    always_comb begin
        // NOTE: every *_d gets a hold default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        acc_d   = acc_q;
        q_d     = q_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    acc_d   = '0;
                    q_d     = b;
                    m_d     = a;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                acc_d = acc_shift;
                q_d   = {sum[0], q_q[WIDTH-1:1]};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    ovf_d   = (acc_shift != '0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            q_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign p    = {acc_q, q_q};
    assign ovf  = ovf_q;

endmodule

// File: doc/mul8_seq.md
# mul8_seq

Sequential 8×8 unsigned shift-add multiplier for the 8-bit microprocessor's execute stage. It sits directly upstream of the existing 8-bit carry-lookahead adder `CLA_8bit`: it feeds that adder one partial-product addition per cycle and consumes its sum and carry-out. A start/busy/done handshake issues one multiply at a time. The 16-bit product and a high-byte-nonzero flag are held until the next accepted start.

## Interface
- `WIDTH`, 8, operand width; only 8 is supported.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled on the rising edge of `clk`.
- `a`  in  8  multiplicand; captured when `start` is accepted.
- `b`  in  8  multiplier; captured when `start` is accepted.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse; high while in DONE.
- `p`  out  16  product, equal to `{acc, q}`.
- `ovf`  out  1  set when `p[15:8] != 0`; registered on entry to DONE.

## Operation
- Registers:
  - `acc[7:0]`: upper half of the product.
  - `q[7:0]`: multiplier, which becomes the lower half of the product.
  - `m[7:0]`: multiplicand.
  - `cnt[3:0]`: iteration counter.
  - `state`: FSM state.
  - `ovf`.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If `start`=1: load `acc`=0, `q`=`b`, `m`=`a`, `cnt`=0, `ovf`=0, then go to RUN.
  - Otherwise stay in IDLE and hold all registers.
- RUN, one iteration per cycle:
  - Adder inputs: A=`acc`, B=(`q[0]` ? `m` : 8'h00), Ci=0. This gives sum S and carry-out Co.
  - Update: `acc` ← {Co, S[7:1]}; `q` ← {S[0], q[7:1]}; `cnt` ← `cnt`+1.
  - When the edge completes the iteration with `cnt`==7: go to DONE and set `ovf` ← ({Co, S[7:1]} != 0).
- DONE:
  - `done`=1.
  - If `start`=1: load exactly as in IDLE and go to RUN (back-to-back operation).
  - Otherwise go to IDLE.
  - `acc` and `q` are held in DONE unless a new start loads them.
- `start` while in RUN is ignored. It is neither queued nor does it disturb the operation in progress.
- Width rule:
  - The product is exact: 0xFF×0xFF = 0xFE01 fits in 16 bits.
  - No bit of Co is ever lost, because it shifts into `acc[7]`.
- `p` during RUN shows partial values. Consumers must read `p` only when `done`=1, or in IDLE after a completed operation.
- `a` and `b` may change freely after the accepting edge.

## Timing
- Reset values: `state`=IDLE; `acc`=`q`=`m`=0; `cnt`=0; `ovf`=0. Therefore `busy`=0, `done`=0, `p`=16'h0000.
- Reset asserted mid-operation aborts immediately. All outputs take their reset values asynchronously, and any `start` during reset is ignored.
- Latency, with start accepted at edge k:
  - `busy`=1 from k through k+8.
  - `done`=1 for exactly the cycle between edges k+8 and k+9, with final `p` and `ovf` valid.
- Throughput: one multiply per 9 cycles when `start` is held or re-asserted in DONE.
- `busy` and `done` are decoded from `state` only. They are glitch-free registered-state decodes with no combinational path from `start`.
- `p` and `ovf` are stable from the DONE cycle until the edge that accepts the next start.
- Critical path: `q[0]` mux → `CLA_8bit` → `acc`/`q` D-inputs. This is one 8-bit CLA delay per cycle.

## Structure
- Shared package/include `mul8_pkg` holds:
  - the state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - `WIDTH`=8;
  - `CNT_LAST`=4'd7.
- One sub-module: a single `CLA_8bit` instance for the per-iteration add.
  - Its S and Co outputs are used.
  - Its OF, PG and GG outputs are left unconnected.
- Everything else (FSM, shift registers, operand mux, counter) is flat in `mul8_seq`.

## Test plan
- Reset, then idle:
  - Assert `rst` asynchronously mid-cycle → `p`=0, `busy`=0, `done`=0, `ovf`=0 immediately.
  - With no start, outputs hold for 20 cycles.
- Basic latency: `a`=13, `b`=11, `start` for one cycle at edge k → `busy` high for k..k+8; `done` exactly one cycle after k+8; `p`=16'h008F; `ovf`=0.
- Maximum operands: `a`=8'hFF, `b`=8'hFF → `p`=16'hFE01, `ovf`=1. Also `a`=0, `b`=8'hA5 → `p`=0, `ovf`=0.
- Handshake corner cases:
  - `start` held high through RUN with changing `a`/`b` → the first operands' result is unaffected (`a`=8'h10, `b`=8'h10 → `p`=16'h0100, `ovf`=1).
  - With `start` still high in DONE, the next operation begins at once and its `done` arrives 9 cycles after the first.
- Reset mid-operation: assert `rst` at the 4th RUN cycle of 0xFF×0xFF → no `done` pulse; all outputs return to reset values. A new start after release gives correct results.
- Random regression: 10,000 random `a`,`b` pairs against the reference model `p`=`a`*`b`, `ovf`=(`a`*`b` > 255). Include all 256×{0,1,0x80,0xFF} edge pairs.
